// File: rtl/tick_pwm_generator.sv
// Tick-based PWM generator. Period and duty are counted in tick_in strobes.
// New period/duty settings are double-buffered and only take effect at a period boundary.
module tick_pwm_generator #(
  parameter int WIDTH      = 8,
  parameter int PERIOD_RST = 9,
  parameter int DUTY_RST   = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             load,
  output logic             load_ack,
  output logic             pwm_out,
  output logic             period_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] period_act, period_act_nx, duty_act, duty_act_nx;
  logic [WIDTH-1:0] period_pend, period_pend_nx, duty_pend, duty_pend_nx;
  logic             pend, pend_nx;
  logic             ack_nx, done_nx, pwm_nx;

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    period_act_nx  = period_act;
    duty_act_nx    = duty_act;
    period_pend_nx = period_pend;
    duty_pend_nx   = duty_pend;
    pend_nx        = pend;
    ack_nx         = 1'b0;
    done_nx        = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pend) begin
          period_act_nx = period_pend;
          duty_act_nx   = duty_pend;
          pend_nx       = 1'b0;
          ack_nx        = 1'b1;
        end
        // A load in the same cycle stays pending for the next edge.
        if (load) begin
          period_pend_nx = period_in;
          duty_pend_nx   = duty_in;
          pend_nx        = 1'b1;
        end
        if (enable) state_nx = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          if (pend) begin
            period_act_nx = period_pend;
            duty_act_nx   = duty_pend;
            pend_nx       = 1'b0;
            ack_nx        = 1'b1;
          end
          if (load) begin
            period_pend_nx = period_in;
            duty_pend_nx   = duty_in;
            pend_nx        = 1'b1;
          end
        end else if (tick_in && (cnt == period_act)) begin
          cnt_nx  = '0;
          done_nx = 1'b1;
          // A load landing on the wrap edge bypasses the pending registers.
          if (load) begin
            period_act_nx = period_in;
            duty_act_nx   = duty_in;
            pend_nx       = 1'b0;
            ack_nx        = 1'b1;
          end else if (pend) begin
            period_act_nx = period_pend;
            duty_act_nx   = duty_pend;
            pend_nx       = 1'b0;
            ack_nx        = 1'b1;
          end
        end else begin
          if (tick_in) cnt_nx = cnt + WIDTH'(1);
          if (load) begin
            period_pend_nx = period_in;
            duty_pend_nx   = duty_in;
            pend_nx        = 1'b1;
          end
        end
      end
    endcase

    pwm_nx = (state_nx == RUN) && (cnt_nx < duty_act_nx);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period_act  <= WIDTH'(PERIOD_RST);
      duty_act    <= WIDTH'(DUTY_RST);
      period_pend <= '0;
      duty_pend   <= '0;
      pend        <= 1'b0;
      pwm_out     <= 1'b0;
      load_ack    <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      period_act  <= period_act_nx;
      duty_act    <= duty_act_nx;
      period_pend <= period_pend_nx;
      duty_pend   <= duty_pend_nx;
      pend        <= pend_nx;
      pwm_out     <= pwm_nx;
      load_ack    <= ack_nx;
      period_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Bench for tick_pwm_generator: directed vector table, strobe-driven waveform
// measurements, and randomized traffic checked against a tick-level model.
module tb_tick_pwm_generator;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1, tick_in = 1'b0, enable = 1'b0, load = 1'b0;
  logic [7:0] period_in = '0, duty_in = '0;
  logic       load_ack, pwm_out, period_done;

  int errors = 0;
  int checks = 0;

  // Tick-level reference: whether running, ticks into the current period,
  // active settings, and at most one pending request (last one wins).
  bit m_run;
  int m_pos, m_p, m_d;
  bit m_has_pend;
  int m_pp, m_pd;
  bit e_pwm, e_ack, e_done;

  tick_pwm_generator #(.WIDTH(8), .PERIOD_RST(9), .DUTY_RST(5)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .enable(enable),
    .period_in(period_in), .duty_in(duty_in), .load(load),
    .load_ack(load_ack), .pwm_out(pwm_out), .period_done(period_done)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_step(bit r, bit en, bit t, bit l, int p, int d);
    e_ack  = 0;
    e_done = 0;
    if (r) begin
      m_run = 0; m_pos = 0; m_p = 9; m_d = 5; m_has_pend = 0;
      e_pwm = 0;
      return;
    end
    if (!m_run || !en) begin
      // Stopped, or stopping now: pending settings are activated right away.
      if (m_has_pend) begin
        m_p = m_pp; m_d = m_pd; m_has_pend = 0; e_ack = 1;
      end
      if (l) begin
        m_pp = p; m_pd = d; m_has_pend = 1;
      end
      m_pos = 0;
      m_run = m_run ? 1'b0 : en;
    end else if (t && m_pos == m_p) begin
      e_done = 1;
      m_pos  = 0;
      if (l) begin
        m_p = p; m_d = d; m_has_pend = 0; e_ack = 1;
      end else if (m_has_pend) begin
        m_p = m_pp; m_d = m_pd; m_has_pend = 0; e_ack = 1;
      end
    end else begin
      if (t) m_pos++;
      if (l) begin
        m_pp = p; m_pd = d; m_has_pend = 1;
      end
    end
    e_pwm = m_run && (m_pos < m_d);
  endfunction

  task automatic step(bit r, bit en, bit t, bit l, int p, int d);
    rst = r; enable = en; tick_in = t; load = l;
    period_in = 8'(p); duty_in = 8'(d);
    @(posedge clk_in);
    model_step(r, en, t, l, p, d);
    #1;
  endtask

  task automatic chk(string name, logic [2:0] got, logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {pwm,ack,done}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_model(string name);
    chk(name, {pwm_out, load_ack, period_done}, {e_pwm, e_ack, e_done});
  endtask

  task automatic chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    bit r, en, t, l;
    int p, d;
    logic [2:0] exp; // {pwm, ack, done}
  } vec_t;

  // Run a strobe of period 4 clocks (tick on the 4th clock) and measure one full
  // PWM cycle between the 2nd and 3rd period_done pulses.
  task automatic measure(string name, int exp_period, int exp_high);
    int dn[$];
    int hi = 0;
    for (int c = 0; c < 400 && dn.size() < 3; c++) begin
      step(0, 1, (c % 4) == 3, 0, 0, 0);
      chk_model({name, "_model"});
      if (period_done) dn.push_back(c);
      if (dn.size() == 2 && pwm_out) hi++;
    end
    chk_int({name, "_done_pulses"}, dn.size(), 3);
    if (dn.size() == 3) begin
      chk_int({name, "_period_clk"}, dn[2] - dn[1], exp_period);
      chk_int({name, "_high_clk"}, hi, exp_high);
    end
  endtask

  initial begin
    vec_t vt[$];
    model_step(1, 0, 0, 0, 0, 0);

    // Directed vectors; expected values derived by hand from the rules.
    vt.push_back('{1,0,0,0,0,0, 3'b000}); // reset
    vt.push_back('{0,0,0,1,1,1, 3'b000}); // load in IDLE captured
    vt.push_back('{0,0,0,0,0,0, 3'b010}); // ack 2 cycles after load
    vt.push_back('{0,1,1,0,0,0, 3'b100}); // enable; coincident tick ignored
    vt.push_back('{0,1,1,0,0,0, 3'b000}); // cnt 1, duty 1 -> low
    vt.push_back('{0,1,0,0,0,0, 3'b000}); // no tick, hold
    vt.push_back('{0,1,1,0,0,0, 3'b101}); // wrap
    vt.push_back('{0,1,1,1,0,0, 3'b000}); // load mid-period, no change
    vt.push_back('{0,1,1,0,0,0, 3'b011}); // wrap applies p=0 d=0
    vt.push_back('{0,1,1,0,0,0, 3'b001}); // period 0: done every tick, duty 0
    vt.push_back('{0,0,0,0,0,0, 3'b000}); // disable
    vt.push_back('{0,1,0,1,4,7, 3'b000}); // enable + load while IDLE
    vt.push_back('{0,1,1,0,0,0, 3'b111}); // wrap applies p=4 d=7
    vt.push_back('{0,1,1,0,0,0, 3'b100}); // duty>period stays high
    vt.push_back('{0,1,1,1,2,2, 3'b100}); // pending load
    vt.push_back('{1,1,1,0,0,0, 3'b000}); // reset discards pend
    vt.push_back('{0,0,0,0,0,0, 3'b000}); // no load_ack from lost pend
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].en, vt[i].t, vt[i].l, vt[i].p, vt[i].d);
      chk($sformatf("vec%0d", i), {pwm_out, load_ack, period_done}, vt[i].exp);
    end

    // Reset defaults: 10 ticks x 4 clk, 5 ticks high.
    step(1, 0, 0, 0, 0, 0);
    chk_model("p1_reset");
    measure("p1", 40, 20);

    // Load in IDLE, then 5-tick period with 2 high ticks.
    step(0, 0, 0, 1, 4, 2);
    chk_model("p2_load");
    step(0, 0, 0, 0, 0, 0);
    chk_int("p2_ack", load_ack, 1);
    measure("p2", 20, 8);

    // Disable mid-period with pending load; restart uses new values.
    for (int c = 0; c < 8; c++) begin
      step(0, 1, (c % 4) == 3, c == 1, 1, 1);
      chk_model("p5_run");
    end
    step(0, 0, 0, 0, 0, 0);
    chk("p5_disable", {pwm_out, load_ack, period_done}, 3'b010);
    measure("p5", 8, 4);

    // Randomized traffic against the model.
    begin
      bit en = 1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 49) == 0) en = !en;
        step($urandom_range(0, 299) == 0, en, $urandom_range(0, 2) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 7), $urandom_range(0, 9));
        chk_model("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
